serial_nibble_add_ctrl: RTL
===========================

// Module: serial_nibble_add_ctrl
// PURPOSE
//   Sequencer that adds two WIDTH-bit unsigned operands using one shared 4-bit adder slice.
//   Processes one nibble per clock, LSB nibble first, and carries the ripple between cycles in a register.
//   Trades latency for area against a fully parallel chain of adder slices.
//   Sits between an operand producer and a result consumer; both sides use valid/ready handshakes.
// PARAMETERS
//   WIDTH    16           operand/result width in bits; multiple of 4, >= 4 (elaboration error otherwise)
//   NIBBLES  WIDTH/4      derived (localparam); number of slice iterations per operation
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands a/b presented
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A; sampled on in_valid&&in_ready
//   b          in   WIDTH  operand B; sampled on in_valid&&in_ready
//   sub        in   1      only with SERIAL_ADD_SUB_EN; 1 = A-B; sampled with operands
//   out_valid  out  1      sum/overflow valid (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   overflow   out  1      add: final carry-out; sub: borrow (= ~final carry-out)
// BEHAVIOUR
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid: latch a/b into shift regs, clear carry reg (set to 1 if sub), cnt=0, go to RUN.
//   RUN: slice adds a_sh[3:0] + b_sh[3:0] (b inverted if sub) + carry; 4-bit result is shifted into sum_sh MSB end.
//     The operand regs shift right 4 and carry <= slice cout. cnt increments.
//     After iteration NIBBLES-1, go to DONE. Exactly NIBBLES cycles in RUN.
//   DONE: out_valid=1; sum and overflow held stable until out_ready; on out_ready go to IDLE.
//   Latency: accept edge to out_valid rise = NIBBLES+1 cycles. Throughput: one op per NIBBLES+2 cycles with out_ready held high.
//   in_ready is combinational from state only; no path from in_valid/out_ready to in_ready/out_valid.
//   in_valid during RUN/DONE is ignored (not accepted); producer holds it.
//   out_ready while not DONE has no effect.
//   sum/overflow update only in RUN; their value outside DONE is don't-care to consumers but deterministic.
//   Reset (any state, incl. mid-RUN): state=IDLE, in_ready=1, out_valid=0, sum=0, overflow=0, carry=0, cnt=0.
//     The in-flight op is discarded and never reported.
//   cnt width = $clog2(NIBBLES) with min 1; must not wrap before terminal compare (NIBBLES=1 legal: one RUN cycle).
// CONFIGURATION
//   SERIAL_ADD_SUB_EN defined: sub port exists.
//     sub=1 -> b nibbles inverted, carry init 1, overflow = borrow (1 when A<B), sum = (A-B) mod 2^WIDTH.
//   SERIAL_ADD_SUB_EN undefined: no sub port; always addition; carry init 0; overflow = carry-out.
//   Latency and handshake are identical in both builds.
// STRUCTURE
//   Package serial_add_pkg: NIBBLE_W=4, state enum (IDLE, RUN, DONE) as typedef sa_state_t.
//   Sub-module adder4_cin: 4-bit ripple adder with carry-in and carry-out, built from full-adder cells.
//     This block instantiates it exactly once. All other logic (FSM, counter, shift regs) is local.
// TESTING (WIDTH=16 unless noted; out_ready=1 unless noted)
//   1. a=0x0001,b=0x000F -> sum=0x0010, overflow=0; out_valid rises 5 cycles after accept.
//   2. a=0xFFFF,b=0x0001 -> sum=0x0000, overflow=1 (carry ripples through all 4 nibbles).
//   3. a=0x1234,b=0x4321, out_ready low 3 cycles in DONE -> sum=0x5555 held stable, out_valid high, in_ready low.
//     New in_valid not accepted until 1 cycle after out_ready handshake.
//   4. Assert rst_n low on the 2nd RUN cycle of a=0x00FF,b=0x0001 -> out_valid/sum/overflow=0 at once, in_ready=1.
//     Next op a=0x0002,b=0x0003 -> sum=0x0005, overflow=0.
//   5. Back-to-back 3 ops with in_valid held high -> each accepted 6 cycles apart, results in order.
//   6. SERIAL_ADD_SUB_EN: sub=1 with 0x0010-0x0001 -> 0x000F, overflow=0; 0x0000-0x0001 -> 0xFFFF, overflow=1.
//     WIDTH=4 build: 0xF+0x1 -> 0x0, overflow=1, out_valid 2 cycles after accept.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial nibble adder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  // Iteration counter width; a single-nibble datapath still needs one bit.
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/serial_nibble_add_ctrl_if.sv
// Operand/result handshake bundle for serial_nibble_add_ctrl; sub exists only with SERIAL_ADD_SUB_EN.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the operand side and the result side.
interface serial_nibble_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             overflow;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output in_valid, a, b, sub, out_ready,
                  input  in_ready, out_valid, sum, overflow);
  modport slave  (input  in_valid, a, b, sub, out_ready,
                  output in_ready, out_valid, sum, overflow);
`else
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, sum, overflow);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, sum, overflow);
`endif
endinterface

// File: rtl/adder4_cin.sv
// 4-bit ripple-carry adder slice built from full-adder cells.
// Latency: combinational.
// Backpressure: none.
module adder4_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];
endmodule

// File: rtl/serial_nibble_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per cycle through a single shared 4-bit slice (SERIAL_ADD_SUB_EN adds A-B).
// Latency: result valid NIBBLES+1 cycles after the accept cycle; one op every NIBBLES+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module serial_nibble_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_nibble_add_ctrl_if.slave bus
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = cnt_width(NIBBLES);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("serial_nibble_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  sa_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     a_sh, b_sh, sum_sh;
  logic                 carry_q, overflow_q;
  logic                 sub_in, sub_mode;
  logic [NIBBLE_W-1:0]  slice_b, slice_s;
  logic                 slice_cout;
  logic [WIDTH-1:0]     sum_next;
  logic                 last_iter;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  assign sub_in   = bus.sub;
  assign sub_mode = sub_q;

  // Operation mode is captured with the operands and held for the whole op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (state_q == IDLE && bus.in_valid) begin
      sub_q <= bus.sub;
    end
  end
`else
  assign sub_in   = 1'b0;
  assign sub_mode = 1'b0;
`endif

  assign last_iter = (cnt_q == CNT_W'(NIBBLES - 1));

  // Subtraction is A + ~B + 1: invert the B nibble, carry register seeded with 1.
  assign slice_b = b_sh[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_mode}};

  adder4_cin u_slice (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Each new result nibble enters at the MSB end so the LSB nibble lands at bit 0 last.
  if (NIBBLES == 1) begin : g_one_nibble
    assign sum_next = slice_s;
  end else begin : g_multi_nibble
    assign sum_next = {slice_s, sum_sh[WIDTH-1:NIBBLE_W]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: handshakes only move the FSM in the state that owns them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_iter)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_sh;
  assign bus.overflow  = overflow_q;

  // Datapath: load on accept, one nibble per RUN cycle, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      sum_sh     <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            carry_q <= sub_in;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_sh       <= a_sh >> NIBBLE_W;
          b_sh       <= b_sh >> NIBBLE_W;
          sum_sh     <= sum_next;
          carry_q    <= slice_cout;
          // Borrow is the inverted carry-out when subtracting.
          overflow_q <= slice_cout ^ sub_mode;
          if (!last_iter) cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
